instrwrap_ctrl_axilite: RTL and testbench

// - AXI4-Lite responder (register file) for the instrumentation wrapper s_axi_ctrl port.
// - Drives traffic-generator/sink config (LFSR seed, enables) to the datapath.
// - Returns the datapath STATUS_I/STATUS_O/LATENCY/INTERVAL/CHECKSUM counters to a host or bench polling master.

---
 rtl/instrwrap_ctrl_axilite.sv | 272 +++++++++++++++++++++++++++
 tb/tb_instrwrap_ctrl_axilite.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instrwrap_ctrl_axilite.sv
// AXI4-Lite control/status register file for the instrumentation wrapper.
// Holds the traffic generator/sink configuration (CFG) and returns the
// datapath counters to a polling master. Write and read channels are
// independent state machines; at most one write and one read in flight.
//
// Build option: define INSTRWRAP_CTRL_IRQ_EN to add the irq output plus the
// IRQ_CFG (0x50) and IRQ_STAT (0x58, write-1-to-clear) registers. Without it
// those addresses decode as unmapped.
//
// Write FSM states:
//   state  | meaning
//   W_IDLE | no beats held, AW and W both accepted
//   W_WAIT | one of AW/W captured, waiting for the other
//   W_RESP | register updated, bvalid high until bready
// Read FSM states:
//   state  | meaning
//   R_IDLE | arready high, waiting for an address
//   R_DATA | snapshot held on rdata, rvalid high until rready

module instrwrap_ctrl_axilite #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axi_ctrl_awaddr,
  input  logic                  s_axi_ctrl_awvalid,
  output logic                  s_axi_ctrl_awready,
  input  logic [31:0]           s_axi_ctrl_wdata,
  input  logic [3:0]            s_axi_ctrl_wstrb,
  input  logic                  s_axi_ctrl_wvalid,
  output logic                  s_axi_ctrl_wready,
  output logic [1:0]            s_axi_ctrl_bresp,
  output logic                  s_axi_ctrl_bvalid,
  input  logic                  s_axi_ctrl_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_ctrl_araddr,
  input  logic                  s_axi_ctrl_arvalid,
  output logic                  s_axi_ctrl_arready,
  output logic [31:0]           s_axi_ctrl_rdata,
  output logic [1:0]            s_axi_ctrl_rresp,
  output logic                  s_axi_ctrl_rvalid,
  input  logic                  s_axi_ctrl_rready,
  output logic                  cfg_gen_en,
  output logic                  cfg_sink_en,
  output logic [15:0]           cfg_lfsr_seed,
`ifdef INSTRWRAP_CTRL_IRQ_EN
  output logic                  irq,
`endif
  input  logic [31:0]           status_i,
  input  logic [31:0]           status_o,
  input  logic [31:0]           latency,
  input  logic [31:0]           interval,
  input  logic [31:0]           checksum
);

  // Byte addresses; the low two address bits are masked before decode.
  localparam logic [31:0] ADDR_MASK      = 32'hFFFF_FFFC;
  localparam logic [31:0] ADDR_CFG       = 32'h0000_0010;
  localparam logic [31:0] ADDR_STATUS_I  = 32'h0000_0018;
  localparam logic [31:0] ADDR_STATUS_O  = 32'h0000_0020;
  localparam logic [31:0] ADDR_LATENCY   = 32'h0000_0028;
  localparam logic [31:0] ADDR_INTERVAL  = 32'h0000_0038;
  localparam logic [31:0] ADDR_CHECKSUM  = 32'h0000_0048;
`ifdef INSTRWRAP_CTRL_IRQ_EN
  localparam logic [31:0] ADDR_IRQ_CFG   = 32'h0000_0050;
  localparam logic [31:0] ADDR_IRQ_STAT  = 32'h0000_0058;
  localparam logic [31:0] IRQ_CFG_MASK   = 32'h0000_01FF;
`endif
  // Implemented CFG bits: seed in [31:16], sink_en [1], gen_en [0].
  localparam logic [31:0] CFG_MASK       = 32'hFFFF_0003;
  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam logic [1:0]  RESP_SLVERR    = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  logic                  r_en;
  wr_state_t             r_wr_state;
  wr_state_t             w_wr_state_nxt;
  rd_state_t             r_rd_state;
  rd_state_t             w_rd_state_nxt;

  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [1:0]            r_bresp;

  logic [31:0]           r_rdata;
  logic [1:0]            r_rresp;
  logic [31:0]           r_cfg;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_wr_commit;
  logic                  w_ar_hs;
  logic [31:0]           w_wr_addr;
  logic [31:0]           w_wr_data;
  logic [31:0]           w_wr_mask;
  logic                  w_wr_ok;
  logic [31:0]           w_rd_addr;
  logic [31:0]           w_rd_data;
  logic [1:0]            w_rd_resp;

`ifdef INSTRWRAP_CTRL_IRQ_EN
  logic [31:0]           r_irq_cfg;
  logic                  r_pending;
  logic                  w_irq_set;
  logic                  w_irq_clr;
`endif

  // Hold all ready outputs low during reset and for the reset-release edge.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_en <= 1'b0;
    else           r_en <= 1'b1;
  end

  // Write FSM: next state, channel readies/valid and commit detection.
  always_comb begin
    w_wr_state_nxt     = r_wr_state;
    s_axi_ctrl_awready = r_en && (r_wr_state != W_RESP) && !r_aw_held;
    s_axi_ctrl_wready  = r_en && (r_wr_state != W_RESP) && !r_w_held;
    s_axi_ctrl_bvalid  = (r_wr_state == W_RESP);
    w_aw_hs            = s_axi_ctrl_awvalid && s_axi_ctrl_awready;
    w_w_hs             = s_axi_ctrl_wvalid && s_axi_ctrl_wready;
    w_wr_commit        = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    case (r_wr_state)
      W_IDLE: begin
        if (w_wr_commit)          w_wr_state_nxt = W_RESP;
        else if (w_aw_hs || w_w_hs) w_wr_state_nxt = W_WAIT;
      end
      W_WAIT: begin
        if (w_wr_commit) w_wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        if (s_axi_ctrl_bready) w_wr_state_nxt = W_IDLE;
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  // Select the committing beat from the held copy or the live channel.
  always_comb begin
    w_wr_addr = (r_aw_held ? 32'(r_awaddr) : 32'(s_axi_ctrl_awaddr)) & ADDR_MASK;
    w_wr_data = r_w_held ? r_wdata : s_axi_ctrl_wdata;
    w_wr_mask = strb_to_mask(r_w_held ? r_wstrb : s_axi_ctrl_wstrb);
    w_wr_ok   = (w_wr_addr == ADDR_CFG);
`ifdef INSTRWRAP_CTRL_IRQ_EN
    if ((w_wr_addr == ADDR_IRQ_CFG) || (w_wr_addr == ADDR_IRQ_STAT)) w_wr_ok = 1'b1;
`endif
  end

  // Write FSM state, beat capture and response code.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wr_state <= W_IDLE;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      if (w_wr_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= s_axi_ctrl_awaddr;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= s_axi_ctrl_wdata;
          r_wstrb  <= s_axi_ctrl_wstrb;
        end
      end
    end
  end

  // CFG register, byte-strobed; unimplemented bits stay zero.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_cfg <= '0;
    end else if (w_wr_commit && (w_wr_addr == ADDR_CFG)) begin
      r_cfg <= ((r_cfg & ~w_wr_mask) | (w_wr_data & w_wr_mask)) & CFG_MASK;
    end
  end

  assign s_axi_ctrl_bresp = r_bresp;
  assign cfg_gen_en       = r_cfg[0];
  assign cfg_sink_en      = r_cfg[1];
  assign cfg_lfsr_seed    = r_cfg[31:16];

`ifdef INSTRWRAP_CTRL_IRQ_EN
  assign w_irq_set = r_irq_cfg[8] && (checksum[31:24] == r_irq_cfg[7:0]);
  assign w_irq_clr = w_wr_commit && (w_wr_addr == ADDR_IRQ_STAT) &&
                     w_wr_mask[0] && w_wr_data[0];

  // IRQ config and sticky pending flag; a new match wins over a clear.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_irq_cfg <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_wr_commit && (w_wr_addr == ADDR_IRQ_CFG))
        r_irq_cfg <= ((r_irq_cfg & ~w_wr_mask) | (w_wr_data & w_wr_mask)) & IRQ_CFG_MASK;
      r_pending <= w_irq_set || (r_pending && !w_irq_clr);
    end
  end

  assign irq = r_pending;
`endif

  // Read FSM: next state and channel handshake signals.
  always_comb begin
    w_rd_state_nxt     = r_rd_state;
    s_axi_ctrl_arready = r_en && (r_rd_state == R_IDLE);
    s_axi_ctrl_rvalid  = (r_rd_state == R_DATA);
    w_ar_hs            = s_axi_ctrl_arvalid && s_axi_ctrl_arready;
    case (r_rd_state)
      R_IDLE:  if (w_ar_hs) w_rd_state_nxt = R_DATA;
      R_DATA:  if (s_axi_ctrl_rready) w_rd_state_nxt = R_IDLE;
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  // Read address decode; unmapped addresses return zero with SLVERR.
  always_comb begin
    w_rd_addr = 32'(s_axi_ctrl_araddr) & ADDR_MASK;
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    case (w_rd_addr)
      ADDR_CFG:      w_rd_data = r_cfg;
      ADDR_STATUS_I: w_rd_data = status_i;
      ADDR_STATUS_O: w_rd_data = status_o;
      ADDR_LATENCY:  w_rd_data = latency;
      ADDR_INTERVAL: w_rd_data = interval;
      ADDR_CHECKSUM: w_rd_data = checksum;
`ifdef INSTRWRAP_CTRL_IRQ_EN
      ADDR_IRQ_CFG:  w_rd_data = r_irq_cfg;
      ADDR_IRQ_STAT: w_rd_data = {31'd0, r_pending};
`endif
      default:       w_rd_resp = RESP_SLVERR;
    endcase
  end

  // Read FSM state; data is snapshotted at the address handshake and held.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rd_state <= R_IDLE;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      if (w_ar_hs) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_resp;
      end
    end
  end

  assign s_axi_ctrl_rdata = r_rdata;
  assign s_axi_ctrl_rresp = r_rresp;

endmodule

// File: tb/tb_instrwrap_ctrl_axilite.sv
// Directed self-checking bench for instrwrap_ctrl_axilite. Inputs change on
// the falling edge, outputs are sampled on the falling edge.
module tb_instrwrap_ctrl_axilite;

  logic        ap_clk;
  logic        ap_rst_n;
  logic [7:0]  s_axi_ctrl_awaddr;
  logic        s_axi_ctrl_awvalid;
  logic        s_axi_ctrl_awready;
  logic [31:0] s_axi_ctrl_wdata;
  logic [3:0]  s_axi_ctrl_wstrb;
  logic        s_axi_ctrl_wvalid;
  logic        s_axi_ctrl_wready;
  logic [1:0]  s_axi_ctrl_bresp;
  logic        s_axi_ctrl_bvalid;
  logic        s_axi_ctrl_bready;
  logic [7:0]  s_axi_ctrl_araddr;
  logic        s_axi_ctrl_arvalid;
  logic        s_axi_ctrl_arready;
  logic [31:0] s_axi_ctrl_rdata;
  logic [1:0]  s_axi_ctrl_rresp;
  logic        s_axi_ctrl_rvalid;
  logic        s_axi_ctrl_rready;
  logic        cfg_gen_en;
  logic        cfg_sink_en;
  logic [15:0] cfg_lfsr_seed;
`ifdef INSTRWRAP_CTRL_IRQ_EN
  logic        irq;
`endif
  logic [31:0] status_i;
  logic [31:0] status_o;
  logic [31:0] latency;
  logic [31:0] interval;
  logic [31:0] checksum;

  int n_pass = 0;
  int n_total = 0;

  instrwrap_ctrl_axilite #(.ADDR_WIDTH(8)) dut (
    .ap_clk             (ap_clk),
    .ap_rst_n           (ap_rst_n),
    .s_axi_ctrl_awaddr  (s_axi_ctrl_awaddr),
    .s_axi_ctrl_awvalid (s_axi_ctrl_awvalid),
    .s_axi_ctrl_awready (s_axi_ctrl_awready),
    .s_axi_ctrl_wdata   (s_axi_ctrl_wdata),
    .s_axi_ctrl_wstrb   (s_axi_ctrl_wstrb),
    .s_axi_ctrl_wvalid  (s_axi_ctrl_wvalid),
    .s_axi_ctrl_wready  (s_axi_ctrl_wready),
    .s_axi_ctrl_bresp   (s_axi_ctrl_bresp),
    .s_axi_ctrl_bvalid  (s_axi_ctrl_bvalid),
    .s_axi_ctrl_bready  (s_axi_ctrl_bready),
    .s_axi_ctrl_araddr  (s_axi_ctrl_araddr),
    .s_axi_ctrl_arvalid (s_axi_ctrl_arvalid),
    .s_axi_ctrl_arready (s_axi_ctrl_arready),
    .s_axi_ctrl_rdata   (s_axi_ctrl_rdata),
    .s_axi_ctrl_rresp   (s_axi_ctrl_rresp),
    .s_axi_ctrl_rvalid  (s_axi_ctrl_rvalid),
    .s_axi_ctrl_rready  (s_axi_ctrl_rready),
    .cfg_gen_en         (cfg_gen_en),
    .cfg_sink_en        (cfg_sink_en),
    .cfg_lfsr_seed      (cfg_lfsr_seed),
`ifdef INSTRWRAP_CTRL_IRQ_EN
    .irq                (irq),
`endif
    .status_i           (status_i),
    .status_o           (status_o),
    .latency            (latency),
    .interval           (interval),
    .checksum           (checksum)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Full write transaction with bounded waits; resp stays X on timeout.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done = 0;
    int n = 0;
    resp = 2'bxx;
    @(negedge ap_clk);
    s_axi_ctrl_awaddr = addr; s_axi_ctrl_wdata = data; s_axi_ctrl_wstrb = strb;
    s_axi_ctrl_awvalid = 1; s_axi_ctrl_wvalid = 1; s_axi_ctrl_bready = 1;
    while (!(aw_done && w_done) && n < 50) begin
      if (s_axi_ctrl_awvalid && s_axi_ctrl_awready) aw_done = 1;
      if (s_axi_ctrl_wvalid && s_axi_ctrl_wready) w_done = 1;
      @(negedge ap_clk); n++;
      if (aw_done) s_axi_ctrl_awvalid = 0;
      if (w_done) s_axi_ctrl_wvalid = 0;
    end
    s_axi_ctrl_awvalid = 0; s_axi_ctrl_wvalid = 0;
    while (!s_axi_ctrl_bvalid && n < 50) begin
      @(negedge ap_clk); n++;
    end
    if (s_axi_ctrl_bvalid) resp = s_axi_ctrl_bresp;
    @(negedge ap_clk);
    s_axi_ctrl_bready = 0;
  endtask

  // Full read transaction with bounded waits; data/resp stay X on timeout.
  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit ar_done = 0;
    int n = 0;
    data = 'x; resp = 2'bxx;
    @(negedge ap_clk);
    s_axi_ctrl_araddr = addr; s_axi_ctrl_arvalid = 1; s_axi_ctrl_rready = 1;
    while (!ar_done && n < 50) begin
      if (s_axi_ctrl_arready) ar_done = 1;
      @(negedge ap_clk); n++;
    end
    s_axi_ctrl_arvalid = 0;
    while (!s_axi_ctrl_rvalid && n < 50) begin
      @(negedge ap_clk); n++;
    end
    if (s_axi_ctrl_rvalid) begin
      data = s_axi_ctrl_rdata; resp = s_axi_ctrl_rresp;
    end
    @(negedge ap_clk);
    s_axi_ctrl_rready = 0;
  endtask

  task automatic test_reset();
    ap_rst_n = 0;
    repeat (3) @(negedge ap_clk);
    n_total++; if (s_axi_ctrl_awready !== 1'b0) $display("FAIL rst_awready got=%b exp=0", s_axi_ctrl_awready); else n_pass++;
    n_total++; if (s_axi_ctrl_wready !== 1'b0) $display("FAIL rst_wready got=%b exp=0", s_axi_ctrl_wready); else n_pass++;
    n_total++; if (s_axi_ctrl_arready !== 1'b0) $display("FAIL rst_arready got=%b exp=0", s_axi_ctrl_arready); else n_pass++;
    n_total++; if (s_axi_ctrl_bvalid !== 1'b0) $display("FAIL rst_bvalid got=%b exp=0", s_axi_ctrl_bvalid); else n_pass++;
    n_total++; if (s_axi_ctrl_rvalid !== 1'b0) $display("FAIL rst_rvalid got=%b exp=0", s_axi_ctrl_rvalid); else n_pass++;
    n_total++; if (s_axi_ctrl_rdata !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", s_axi_ctrl_rdata); else n_pass++;
    n_total++; if ({s_axi_ctrl_bresp, s_axi_ctrl_rresp} !== 4'b0000) $display("FAIL rst_resp got=%b exp=0000", {s_axi_ctrl_bresp, s_axi_ctrl_rresp}); else n_pass++;
    n_total++; if ({cfg_lfsr_seed, cfg_sink_en, cfg_gen_en} !== 18'h0) $display("FAIL rst_cfg got=%h exp=0", {cfg_lfsr_seed, cfg_sink_en, cfg_gen_en}); else n_pass++;
`ifdef INSTRWRAP_CTRL_IRQ_EN
    n_total++; if (irq !== 1'b0) $display("FAIL rst_irq got=%b exp=0", irq); else n_pass++;
`endif
    ap_rst_n = 1;
    #1;
    n_total++; if (s_axi_ctrl_awready !== 1'b0) $display("FAIL rel_awready_early got=%b exp=0", s_axi_ctrl_awready); else n_pass++;
    @(negedge ap_clk);
    n_total++; if ({s_axi_ctrl_awready, s_axi_ctrl_wready, s_axi_ctrl_arready} !== 3'b111) $display("FAIL rel_readies got=%b exp=111", {s_axi_ctrl_awready, s_axi_ctrl_wready, s_axi_ctrl_arready}); else n_pass++;
  endtask

  task automatic test_cfg_write();
    logic [1:0] resp;
    logic [31:0] rd;
    axi_write(8'h10, 32'h0001_0003, 4'hF, resp);
    n_total++; if (resp !== 2'b00) $display("FAIL cfg_bresp got=%b exp=00", resp); else n_pass++;
    n_total++; if ({cfg_lfsr_seed, cfg_sink_en, cfg_gen_en} !== {16'h0001, 1'b1, 1'b1}) $display("FAIL cfg_outputs got=%h exp=%h", {cfg_lfsr_seed, cfg_sink_en, cfg_gen_en}, {16'h0001, 1'b1, 1'b1}); else n_pass++;
    axi_read(8'h10, rd, resp);
    n_total++; if (rd !== 32'h0001_0003 || resp !== 2'b00) $display("FAIL cfg_readback got=%h/%b exp=00010003/00", rd, resp); else n_pass++;
  endtask

  task automatic test_strb();
    logic [1:0] resp;
    logic [31:0] rd;
    axi_write(8'h10, 32'hABCD_FFFF, 4'h4, resp);
    axi_read(8'h10, rd, resp);
    n_total++; if (rd !== 32'h00CD_0003) $display("FAIL strb_byte2 got=%h exp=00cd0003", rd); else n_pass++;
    axi_write(8'h10, 32'h0000_00FE, 4'h1, resp);
    axi_read(8'h10, rd, resp);
    n_total++; if (rd !== 32'h00CD_0002) $display("FAIL strb_byte0_raz got=%h exp=00cd0002", rd); else n_pass++;
  endtask

  task automatic test_aw_before_w();
    @(negedge ap_clk);
    s_axi_ctrl_awaddr = 8'h10; s_axi_ctrl_awvalid = 1;
    s_axi_ctrl_wdata = 32'h1234_0001; s_axi_ctrl_wstrb = 4'hF; s_axi_ctrl_bready = 0;
    n_total++; if (s_axi_ctrl_awready !== 1'b1) $display("FAIL awfirst_awready got=%b exp=1", s_axi_ctrl_awready); else n_pass++;
    @(negedge ap_clk);
    s_axi_ctrl_awvalid = 0;
    n_total++; if ({s_axi_ctrl_awready, s_axi_ctrl_wready, s_axi_ctrl_bvalid} !== 3'b010) $display("FAIL awfirst_after_aw got=%b exp=010", {s_axi_ctrl_awready, s_axi_ctrl_wready, s_axi_ctrl_bvalid}); else n_pass++;
    @(negedge ap_clk);
    @(negedge ap_clk);
    s_axi_ctrl_wvalid = 1;
    n_total++; if ({cfg_lfsr_seed, s_axi_ctrl_bvalid} !== {16'h00CD, 1'b0}) $display("FAIL awfirst_pre_update got=%h exp=%h", {cfg_lfsr_seed, s_axi_ctrl_bvalid}, {16'h00CD, 1'b0}); else n_pass++;
    @(negedge ap_clk);
    s_axi_ctrl_wvalid = 0;
    n_total++; if (s_axi_ctrl_bvalid !== 1'b1 || s_axi_ctrl_bresp !== 2'b00) $display("FAIL awfirst_bvalid got=%b/%b exp=1/00", s_axi_ctrl_bvalid, s_axi_ctrl_bresp); else n_pass++;
    n_total++; if ({cfg_lfsr_seed, cfg_sink_en, cfg_gen_en} !== {16'h1234, 1'b0, 1'b1}) $display("FAIL awfirst_cfg got=%h exp=%h", {cfg_lfsr_seed, cfg_sink_en, cfg_gen_en}, {16'h1234, 1'b0, 1'b1}); else n_pass++;
    n_total++; if ({s_axi_ctrl_awready, s_axi_ctrl_wready} !== 2'b00) $display("FAIL awfirst_resp_readies got=%b exp=00", {s_axi_ctrl_awready, s_axi_ctrl_wready}); else n_pass++;
    s_axi_ctrl_bready = 1;
    @(negedge ap_clk);
    s_axi_ctrl_bready = 0;
    n_total++; if (s_axi_ctrl_bvalid !== 1'b0) $display("FAIL awfirst_bdone got=%b exp=0", s_axi_ctrl_bvalid); else n_pass++;
  endtask

  task automatic test_w_before_aw();
    @(negedge ap_clk);
    s_axi_ctrl_wdata = 32'h5678_0002; s_axi_ctrl_wstrb = 4'hF; s_axi_ctrl_wvalid = 1;
    s_axi_ctrl_awaddr = 8'h10; s_axi_ctrl_bready = 0;
    @(negedge ap_clk);
    s_axi_ctrl_wvalid = 0;
    n_total++; if ({s_axi_ctrl_awready, s_axi_ctrl_wready, s_axi_ctrl_bvalid} !== 3'b100) $display("FAIL wfirst_after_w got=%b exp=100", {s_axi_ctrl_awready, s_axi_ctrl_wready, s_axi_ctrl_bvalid}); else n_pass++;
    @(negedge ap_clk);
    @(negedge ap_clk);
    s_axi_ctrl_awvalid = 1;
    n_total++; if ({cfg_lfsr_seed, s_axi_ctrl_bvalid} !== {16'h1234, 1'b0}) $display("FAIL wfirst_pre_update got=%h exp=%h", {cfg_lfsr_seed, s_axi_ctrl_bvalid}, {16'h1234, 1'b0}); else n_pass++;
    @(negedge ap_clk);
    s_axi_ctrl_awvalid = 0;
    n_total++; if (s_axi_ctrl_bvalid !== 1'b1 || s_axi_ctrl_bresp !== 2'b00) $display("FAIL wfirst_bvalid got=%b/%b exp=1/00", s_axi_ctrl_bvalid, s_axi_ctrl_bresp); else n_pass++;
    n_total++; if ({cfg_lfsr_seed, cfg_sink_en, cfg_gen_en} !== {16'h5678, 1'b1, 1'b0}) $display("FAIL wfirst_cfg got=%h exp=%h", {cfg_lfsr_seed, cfg_sink_en, cfg_gen_en}, {16'h5678, 1'b1, 1'b0}); else n_pass++;
    s_axi_ctrl_bready = 1;
    @(negedge ap_clk);
    s_axi_ctrl_bready = 0;
  endtask

  task automatic test_cfg_read_during_write();
    @(negedge ap_clk);
    s_axi_ctrl_awaddr = 8'h10; s_axi_ctrl_awvalid = 1;
    s_axi_ctrl_wdata = 32'h9ABC_0003; s_axi_ctrl_wstrb = 4'hF;
    s_axi_ctrl_bready = 0; s_axi_ctrl_rready = 0;
    @(negedge ap_clk);
    s_axi_ctrl_awvalid = 0;
    s_axi_ctrl_wvalid = 1; s_axi_ctrl_araddr = 8'h10; s_axi_ctrl_arvalid = 1;
    @(negedge ap_clk);
    s_axi_ctrl_wvalid = 0; s_axi_ctrl_arvalid = 0;
    n_total++; if (s_axi_ctrl_rvalid !== 1'b1 || s_axi_ctrl_rdata !== 32'h5678_0002) $display("FAIL rdwr_old_value got=%b/%h exp=1/56780002", s_axi_ctrl_rvalid, s_axi_ctrl_rdata); else n_pass++;
    n_total++; if (cfg_lfsr_seed !== 16'h9ABC || s_axi_ctrl_bvalid !== 1'b1) $display("FAIL rdwr_new_cfg got=%h/%b exp=9abc/1", cfg_lfsr_seed, s_axi_ctrl_bvalid); else n_pass++;
    s_axi_ctrl_bready = 1; s_axi_ctrl_rready = 1;
    @(negedge ap_clk);
    s_axi_ctrl_bready = 0; s_axi_ctrl_rready = 0;
    n_total++; if ({s_axi_ctrl_bvalid, s_axi_ctrl_rvalid} !== 2'b00) $display("FAIL rdwr_done got=%b exp=00", {s_axi_ctrl_bvalid, s_axi_ctrl_rvalid}); else n_pass++;
  endtask

  task automatic test_read_snapshot();
    @(negedge ap_clk);
    checksum = 32'h2F00_1234;
    s_axi_ctrl_araddr = 8'h48; s_axi_ctrl_arvalid = 1; s_axi_ctrl_rready = 0;
    n_total++; if (s_axi_ctrl_arready !== 1'b1) $display("FAIL snap_arready got=%b exp=1", s_axi_ctrl_arready); else n_pass++;
    @(negedge ap_clk);
    s_axi_ctrl_arvalid = 0;
    checksum = 32'hDEAD_BEEF;
    n_total++; if (s_axi_ctrl_rvalid !== 1'b1 || s_axi_ctrl_rdata !== 32'h2F00_1234 || s_axi_ctrl_rresp !== 2'b00) $display("FAIL snap_first got=%b/%h/%b exp=1/2f001234/00", s_axi_ctrl_rvalid, s_axi_ctrl_rdata, s_axi_ctrl_rresp); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      n_total++; if ({s_axi_ctrl_rvalid, s_axi_ctrl_arready, s_axi_ctrl_rdata} !== {1'b1, 1'b0, 32'h2F00_1234}) $display("FAIL snap_stall%0d got=%b/%b/%h exp=1/0/2f001234", i, s_axi_ctrl_rvalid, s_axi_ctrl_arready, s_axi_ctrl_rdata); else n_pass++;
    end
    s_axi_ctrl_rready = 1;
    @(negedge ap_clk);
    s_axi_ctrl_rready = 0;
    n_total++; if ({s_axi_ctrl_rvalid, s_axi_ctrl_arready} !== 2'b01) $display("FAIL snap_done got=%b exp=01", {s_axi_ctrl_rvalid, s_axi_ctrl_arready}); else n_pass++;
  endtask

  task automatic test_status_reads();
    logic [7:0]  addrs [6] = '{8'h18, 8'h20, 8'h28, 8'h38, 8'h48, 8'h1B};
    logic [31:0] exps  [6] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003,
                               32'h4444_0004, 32'h5555_0005, 32'h1111_0001};
    logic [1:0]  resp;
    logic [31:0] rd;
    status_i = 32'h1111_0001; status_o = 32'h2222_0002; latency = 32'h3333_0003;
    interval = 32'h4444_0004; checksum = 32'h5555_0005;
    for (int i = 0; i < 6; i++) begin
      axi_read(addrs[i], rd, resp);
      n_total++; if (rd !== exps[i] || resp !== 2'b00) $display("FAIL status_read addr=%h got=%h/%b exp=%h/00", addrs[i], rd, resp, exps[i]); else n_pass++;
    end
  endtask

  task automatic test_errors();
    logic [1:0]  resp;
    logic [31:0] rd;
    axi_read(8'h30, rd, resp);
    n_total++; if (rd !== 32'h0 || resp !== 2'b10) $display("FAIL err_read30 got=%h/%b exp=00000000/10", rd, resp); else n_pass++;
    axi_read(8'h14, rd, resp);
    n_total++; if (rd !== 32'h0 || resp !== 2'b10) $display("FAIL err_read14 got=%h/%b exp=00000000/10", rd, resp); else n_pass++;
    axi_write(8'h18, 32'hFFFF_FFFF, 4'hF, resp);
    n_total++; if (resp !== 2'b10) $display("FAIL err_write18 got=%b exp=10", resp); else n_pass++;
    n_total++; if ({cfg_lfsr_seed, cfg_sink_en, cfg_gen_en} !== {16'h9ABC, 1'b1, 1'b1}) $display("FAIL err_cfg_kept got=%h exp=%h", {cfg_lfsr_seed, cfg_sink_en, cfg_gen_en}, {16'h9ABC, 1'b1, 1'b1}); else n_pass++;
    axi_read(8'h18, rd, resp);
    n_total++; if (rd !== 32'h1111_0001 || resp !== 2'b00) $display("FAIL err_status_kept got=%h/%b exp=11110001/00", rd, resp); else n_pass++;
`ifndef INSTRWRAP_CTRL_IRQ_EN
    axi_write(8'h50, 32'h0000_012F, 4'hF, resp);
    n_total++; if (resp !== 2'b10) $display("FAIL err_write50 got=%b exp=10", resp); else n_pass++;
    axi_read(8'h58, rd, resp);
    n_total++; if (rd !== 32'h0 || resp !== 2'b10) $display("FAIL err_read58 got=%h/%b exp=00000000/10", rd, resp); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [1:0]  resp;
    logic [31:0] rd;
    axi_write(8'h10, 32'h0000_0001, 4'hF, resp);
    axi_write(8'h10, 32'h0000_0002, 4'hF, resp);
    n_total++; if (resp !== 2'b00 || {cfg_lfsr_seed, cfg_sink_en, cfg_gen_en} !== {16'h0000, 1'b1, 1'b0}) $display("FAIL b2b_write got=%b/%h exp=00/%h", resp, {cfg_lfsr_seed, cfg_sink_en, cfg_gen_en}, {16'h0000, 1'b1, 1'b0}); else n_pass++;
    axi_read(8'h20, rd, resp);
    n_total++; if (rd !== 32'h2222_0002) $display("FAIL b2b_read1 got=%h exp=22220002", rd); else n_pass++;
    axi_read(8'h28, rd, resp);
    n_total++; if (rd !== 32'h3333_0003) $display("FAIL b2b_read2 got=%h exp=33330003", rd); else n_pass++;
  endtask

`ifdef INSTRWRAP_CTRL_IRQ_EN
  task automatic test_irq();
    logic [1:0]  resp;
    logic [31:0] rd;
    checksum = 32'h2E00_0000;
    axi_write(8'h50, 32'h0000_012F, 4'hF, resp);
    n_total++; if (resp !== 2'b00) $display("FAIL irq_cfg_bresp got=%b exp=00", resp); else n_pass++;
    axi_read(8'h50, rd, resp);
    n_total++; if (rd !== 32'h0000_012F) $display("FAIL irq_cfg_read got=%h exp=0000012f", rd); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL irq_nomatch got=%b exp=0", irq); else n_pass++;
    checksum = 32'h2F00_0000;
    #1;
    n_total++; if (irq !== 1'b0) $display("FAIL irq_same_cycle got=%b exp=0", irq); else n_pass++;
    @(negedge ap_clk);
    n_total++; if (irq !== 1'b1) $display("FAIL irq_set got=%b exp=1", irq); else n_pass++;
    axi_read(8'h58, rd, resp);
    n_total++; if (rd !== 32'h1 || resp !== 2'b00) $display("FAIL irq_stat_read got=%h/%b exp=00000001/00", rd, resp); else n_pass++;
    axi_write(8'h58, 32'h1, 4'hF, resp);
    n_total++; if (irq !== 1'b1) $display("FAIL irq_set_beats_clr got=%b exp=1", irq); else n_pass++;
    checksum = 32'h3000_0000;
    axi_write(8'h58, 32'h1, 4'hF, resp);
    n_total++; if (irq !== 1'b0 || resp !== 2'b00) $display("FAIL irq_w1c got=%b/%b exp=0/00", irq, resp); else n_pass++;
  endtask
`endif

  task automatic test_reset_mid_write();
    @(negedge ap_clk);
    s_axi_ctrl_awaddr = 8'h10; s_axi_ctrl_awvalid = 1;
    @(negedge ap_clk);
    s_axi_ctrl_awvalid = 0;
    n_total++; if ({s_axi_ctrl_awready, s_axi_ctrl_wready} !== 2'b01) $display("FAIL midrst_aw_held got=%b exp=01", {s_axi_ctrl_awready, s_axi_ctrl_wready}); else n_pass++;
    ap_rst_n = 0;
    #1;
    n_total++; if ({s_axi_ctrl_awready, s_axi_ctrl_wready, s_axi_ctrl_arready, s_axi_ctrl_bvalid, s_axi_ctrl_rvalid} !== 5'b0) $display("FAIL midrst_ctrl got=%b exp=00000", {s_axi_ctrl_awready, s_axi_ctrl_wready, s_axi_ctrl_arready, s_axi_ctrl_bvalid, s_axi_ctrl_rvalid}); else n_pass++;
    n_total++; if ({cfg_lfsr_seed, cfg_sink_en, cfg_gen_en, s_axi_ctrl_rdata} !== 50'h0) $display("FAIL midrst_data got=%h exp=0", {cfg_lfsr_seed, cfg_sink_en, cfg_gen_en, s_axi_ctrl_rdata}); else n_pass++;
    @(negedge ap_clk);
    ap_rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk);
      n_total++; if (s_axi_ctrl_bvalid !== 1'b0) $display("FAIL midrst_no_b%0d got=%b exp=0", i, s_axi_ctrl_bvalid); else n_pass++;
    end
    n_total++; if ({s_axi_ctrl_awready, s_axi_ctrl_wready, s_axi_ctrl_arready} !== 3'b111) $display("FAIL midrst_readies got=%b exp=111", {s_axi_ctrl_awready, s_axi_ctrl_wready, s_axi_ctrl_arready}); else n_pass++;
  endtask

  initial begin
    ap_rst_n = 0;
    s_axi_ctrl_awaddr = '0; s_axi_ctrl_awvalid = 0;
    s_axi_ctrl_wdata = '0; s_axi_ctrl_wstrb = '0; s_axi_ctrl_wvalid = 0;
    s_axi_ctrl_bready = 0;
    s_axi_ctrl_araddr = '0; s_axi_ctrl_arvalid = 0; s_axi_ctrl_rready = 0;
    status_i = '0; status_o = '0; latency = '0; interval = '0; checksum = '0;
    test_reset();
    test_cfg_write();
    test_strb();
    test_aw_before_w();
    test_w_before_aw();
    test_cfg_read_during_write();
    test_read_snapshot();
    test_status_reads();
    test_errors();
    test_back_to_back();
`ifdef INSTRWRAP_CTRL_IRQ_EN
    test_irq();
`endif
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
